// File: rtl/rv32im_branch_pkg.sv
// rv32im_branch_pkg
// Shared types and constants for the execute-stage branch resolver.
//   br_type_e : instruction class presented with each resolver input
//   F3_*      : funct3 encodings of the six RV32I conditional branches
//   state_e   : resolver control state (normal flow / wrong-path drain)
package rv32im_branch_pkg;

  typedef enum logic [1:0] {
    BR_COND = 2'b00,
    BR_JAL  = 2'b01,
    BR_JALR = 2'b10,
    BR_NONE = 2'b11
  } br_type_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/branch_cond_decode.sv
// branch_cond_decode
// Combinational decode of a conditional branch outcome from the ALU
// comparator flags.
// Ports:
//   funct3       in  3  branch condition field
//   cmp_greater  in  1  signed rs1 > rs2
//   cmp_equal    in  1  rs1 == rs2
//   cmp_less     in  1  signed rs1 < rs2
//   cmp_ltu      in  1  unsigned rs1 < rs2
//   taken        out 1  condition holds
//   illegal      out 1  funct3 is not a branch encoding (010/011)
module branch_cond_decode
  import rv32im_branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       cmp_greater,
  input  logic       cmp_equal,
  input  logic       cmp_less,
  input  logic       cmp_ltu,
  output logic       taken,
  output logic       illegal
);

  // Signed greater-or-equal is derived as !less, so the greater flag is
  // redundant here; it is kept on the port so the comparator bundle can be
  // wired straight through.
  logic unused_greater;
  assign unused_greater = cmp_greater;

  // Map funct3 onto the comparator flags. The two reserved encodings fall
  // through to the default arm: never taken and flagged illegal.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = cmp_equal;
      F3_BNE:  taken = !cmp_equal;
      F3_BLT:  taken = cmp_less;
      F3_BGE:  taken = !cmp_less;
      F3_BLTU: taken = cmp_ltu;
      F3_BGEU: taken = !cmp_ltu;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Execute-stage branch resolver: decides direction, computes the target and
// link address, compares against the fetch prediction and issues a one-cycle
// front-end redirect, then discards wrong-path inputs for DRAIN_CYCLES cycles.
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   in_valid / in_ready          upstream handshake
//   br_type, funct3              instruction class and branch condition
//   pc, imm, rs1                 PC, sign-extended immediate, rs1 value
//   pred_taken                   fetch-stage direction prediction
//   cmp_greater/equal/less/ltu   comparator flags
//   flush_in                     synchronous kill from a later stage
//   out_valid / out_ready        downstream handshake
//   out_taken, out_target        resolved direction and target
//   out_link                     pc+4
//   out_illegal, out_misalign    bad funct3 / taken target with bit 1 set
//   redirect, redirect_pc        one-cycle fetch restart pulse and address
//   branch_cnt, mispredict_cnt   saturating performance counters
module branch_resolve_unit
  import rv32im_branch_pkg::*;
#(
  parameter int data_width   = 32,
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            br_type,
  input  logic [2:0]            funct3,
  input  logic [data_width-1:0] pc,
  input  logic [data_width-1:0] imm,
  input  logic [data_width-1:0] rs1,
  input  logic                  pred_taken,
  input  logic                  cmp_greater,
  input  logic                  cmp_equal,
  input  logic                  cmp_less,
  input  logic                  cmp_ltu,
  input  logic                  flush_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_taken,
  output logic [data_width-1:0] out_target,
  output logic [data_width-1:0] out_link,
  output logic                  out_illegal,
  output logic                  out_misalign,
  output logic                  redirect,
  output logic [data_width-1:0] redirect_pc,
  output logic [CNT_W-1:0]      branch_cnt,
  output logic [CNT_W-1:0]      mispredict_cnt
);

  localparam int                 DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

  br_type_e              br_kind;
  state_e                state, state_next;
  logic [DRAIN_W-1:0]    drain_cnt, drain_next;

  logic                  dec_taken, dec_illegal;
  logic [data_width-1:0] pc_sum, rs1_sum, link;
  logic [data_width-1:0] target;
  logic                  taken, illegal, misalign, mispredict;
  logic                  redirect_now, is_cond, accept;

  assign br_kind = br_type_e'(br_type);

  branch_cond_decode u_cond (
    .funct3      (funct3),
    .cmp_greater (cmp_greater),
    .cmp_equal   (cmp_equal),
    .cmp_less    (cmp_less),
    .cmp_ltu     (cmp_ltu),
    .taken       (dec_taken),
    .illegal     (dec_illegal)
  );

  // Both adders wrap silently at data_width bits, as the ISA requires.
  assign pc_sum  = pc + imm;
  assign rs1_sum = rs1 + imm;
  assign link    = pc + data_width'(4);

  // Resolve direction, target and prediction check for the incoming
  // instruction. JALR is never predicted by fetch, so it always counts as a
  // mispredict. A taken target with bit 1 set is misaligned and must not
  // steer fetch, so it suppresses the redirect.
  always_comb begin
    taken      = 1'b0;
    illegal    = 1'b0;
    mispredict = 1'b0;
    target     = pc_sum;
    case (br_kind)
      BR_COND: begin
        taken      = dec_taken;
        illegal    = dec_illegal;
        mispredict = dec_taken != pred_taken;
      end
      BR_JAL: begin
        taken      = 1'b1;
        mispredict = !pred_taken;
      end
      BR_JALR: begin
        taken      = 1'b1;
        target     = rs1_sum & ~data_width'(1);
        mispredict = 1'b1;
      end
      default: begin
        taken      = 1'b0;
        mispredict = 1'b0;
      end
    endcase
    misalign     = taken && target[1];
    redirect_now = mispredict && !misalign;
  end

  assign is_cond = (br_kind == BR_COND);

  // While draining, inputs are swallowed regardless of downstream state;
  // in normal flow the output register accepts when empty or being emptied.
  assign in_ready = (state == DRAIN) || !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush_in && (state == RUN);

  // Control state register and drain countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_next;
    end
  end

  // Next-state logic. A flush wins over everything and returns to RUN. In
  // RUN a redirecting instruction starts the drain window; in DRAIN the
  // counter steps down every cycle and hands back to RUN once it reaches 1.
  always_comb begin
    state_next = state;
    drain_next = drain_cnt;
    if (flush_in) begin
      state_next = RUN;
      drain_next = '0;
    end else begin
      case (state)
        RUN: begin
          if (accept && redirect_now) begin
            state_next = DRAIN;
            drain_next = DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (drain_cnt <= DRAIN_ONE) begin
            state_next = RUN;
            drain_next = '0;
          end else begin
            drain_next = drain_cnt - DRAIN_ONE;
          end
        end
      endcase
    end
  end

  // Output pipeline register. Results load only on accept, so they stay
  // frozen while the consumer stalls. The redirect pulse defaults low every
  // cycle, which makes it last exactly one cycle and never repeat during a
  // stall; a flush clears the valid and kills any redirect for that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_taken    <= 1'b0;
      out_target   <= '0;
      out_link     <= '0;
      out_illegal  <= 1'b0;
      out_misalign <= 1'b0;
      redirect     <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      redirect <= 1'b0;
      if (flush_in) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid    <= 1'b1;
        out_taken    <= taken;
        out_target   <= target;
        out_link     <= link;
        out_illegal  <= illegal;
        out_misalign <= misalign;
        redirect     <= redirect_now;
        redirect_pc  <= taken ? target : link;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Saturating performance counters. Only accepted instructions count, so
  // drained and flushed inputs are ignored automatically.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (accept && is_cond && (branch_cnt != '1)) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (accept && redirect_now && (mispredict_cnt != '1)) begin
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit
// Directed bench for branch_resolve_unit: a table of single-instruction
// vectors with hand-computed results, followed by hand-written sequences for
// drain, backpressure, flush, counter saturation and reset mid-drain.
// A second instance with 3-bit counters shares the stimulus so that
// saturation is reachable in a short run.
module tb_branch_resolve_unit;
  import rv32im_branch_pkg::*;

  localparam int DW   = 32;
  localparam int CW   = 16;
  localparam int SATW = 3;
  localparam int SATMAX = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [1:0] br_type = 2'b11;
  logic [2:0] funct3 = 3'b000;
  logic [DW-1:0] pc = '0, imm = '0, rs1 = '0;
  logic pred_taken = 1'b0;
  logic cmp_greater = 1'b0, cmp_equal = 1'b0, cmp_less = 1'b0, cmp_ltu = 1'b0;
  logic flush_in = 1'b0;
  logic out_ready = 1'b1;

  logic in_ready, out_valid, out_taken, out_illegal, out_misalign, redirect;
  logic [DW-1:0] out_target, out_link, redirect_pc;
  logic [CW-1:0] branch_cnt, mispredict_cnt;

  logic sat_in_ready, sat_out_valid, sat_out_taken, sat_out_illegal;
  logic sat_out_misalign, sat_redirect;
  logic [DW-1:0] sat_out_target, sat_out_link, sat_redirect_pc;
  logic [SATW-1:0] sat_branch_cnt, sat_mispredict_cnt;

  branch_resolve_unit #(.data_width(DW), .CNT_W(CW), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .br_type(br_type), .funct3(funct3), .pc(pc), .imm(imm), .rs1(rs1),
    .pred_taken(pred_taken), .cmp_greater(cmp_greater), .cmp_equal(cmp_equal),
    .cmp_less(cmp_less), .cmp_ltu(cmp_ltu), .flush_in(flush_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .out_link(out_link), .out_illegal(out_illegal),
    .out_misalign(out_misalign), .redirect(redirect), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  branch_resolve_unit #(.data_width(DW), .CNT_W(SATW), .DRAIN_CYCLES(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
    .br_type(br_type), .funct3(funct3), .pc(pc), .imm(imm), .rs1(rs1),
    .pred_taken(pred_taken), .cmp_greater(cmp_greater), .cmp_equal(cmp_equal),
    .cmp_less(cmp_less), .cmp_ltu(cmp_ltu), .flush_in(flush_in),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_taken(sat_out_taken),
    .out_target(sat_out_target), .out_link(sat_out_link),
    .out_illegal(sat_out_illegal), .out_misalign(sat_out_misalign),
    .redirect(sat_redirect), .redirect_pc(sat_redirect_pc),
    .branch_cnt(sat_branch_cnt), .mispredict_cnt(sat_mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    bt;
    logic [2:0]    f3;
    logic [DW-1:0] pc;
    logic [DW-1:0] imm;
    logic [DW-1:0] rs1;
    logic          pred;
    logic          eq;
    logic          lt;
    logic          ltu;
    logic          exp_taken;
    logic [DW-1:0] exp_target;
    logic          exp_illegal;
    logic          exp_misalign;
    logic          exp_redirect;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;
  int exp_branch = 0;
  int exp_mis = 0;

  function automatic vec_t mk(input logic [1:0] bt, input logic [2:0] f3,
                              input logic [DW-1:0] p, input logic [DW-1:0] im,
                              input logic [DW-1:0] r1, input logic pt,
                              input logic eq, input logic lt, input logic ltu,
                              input logic et, input logic [DW-1:0] etg,
                              input logic eill, input logic emis, input logic ered);
    vec_t v;
    v.bt = bt; v.f3 = f3; v.pc = p; v.imm = im; v.rs1 = r1; v.pred = pt;
    v.eq = eq; v.lt = lt; v.ltu = ltu;
    v.exp_taken = et; v.exp_target = etg; v.exp_illegal = eill;
    v.exp_misalign = emis; v.exp_redirect = ered;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkOutput(name, {31'b0, actual}, {31'b0, expected});
  endtask

  task automatic checkCounters(input string tag);
    int sb, sm;
    sb = (exp_branch > SATMAX) ? SATMAX : exp_branch;
    sm = (exp_mis > SATMAX) ? SATMAX : exp_mis;
    checkOutput({tag, ".branch_cnt"}, {16'b0, branch_cnt}, 32'(exp_branch));
    checkOutput({tag, ".mispredict_cnt"}, {16'b0, mispredict_cnt}, 32'(exp_mis));
    checkOutput({tag, ".sat_branch_cnt"}, {29'b0, sat_branch_cnt}, 32'(sb));
    checkOutput({tag, ".sat_mispredict_cnt"}, {29'b0, sat_mispredict_cnt}, 32'(sm));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] bt, input logic [2:0] f3,
                       input logic [DW-1:0] p, input logic [DW-1:0] im,
                       input logic [DW-1:0] r1, input logic pt,
                       input logic eq, input logic lt, input logic ltu);
    br_type = bt; funct3 = f3; pc = p; imm = im; rs1 = r1; pred_taken = pt;
    cmp_equal = eq; cmp_less = lt; cmp_ltu = ltu;
    cmp_greater = !eq && !lt;
    in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    flush_in = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input vec_t v);
    out_ready = 1'b1;
    drive(v.bt, v.f3, v.pc, v.imm, v.rs1, v.pred, v.eq, v.lt, v.ltu);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic checkVector(input vec_t v, input int i);
    string t;
    logic [DW-1:0] lnk;
    t = $sformatf("v%0d", i);
    lnk = v.pc + 32'd4;
    checkBit({t, ".out_valid"}, out_valid, 1'b1);
    checkBit({t, ".taken"}, out_taken, v.exp_taken);
    checkOutput({t, ".target"}, out_target, v.exp_target);
    checkOutput({t, ".link"}, out_link, lnk);
    checkBit({t, ".illegal"}, out_illegal, v.exp_illegal);
    checkBit({t, ".misalign"}, out_misalign, v.exp_misalign);
    checkBit({t, ".redirect"}, redirect, v.exp_redirect);
    checkOutput({t, ".redirect_pc"}, redirect_pc, v.exp_taken ? v.exp_target : lnk);
  endtask

  initial begin
    // bt,  f3,     pc,           imm,          rs1,          pr eq lt lu  tk target        il ma rd
    vecs[0]  = mk(2'b00, 3'b000, 32'h0000_0100, 32'h0000_0020, 32'h0,         0, 1, 0, 0, 1, 32'h0000_0120, 0, 0, 1);
    vecs[1]  = mk(2'b00, 3'b001, 32'h0000_0200, 32'h0000_0042, 32'h0,         0, 1, 0, 0, 0, 32'h0000_0242, 0, 0, 0);
    vecs[2]  = mk(2'b00, 3'b100, 32'h0000_0300, 32'hFFFF_FFF8, 32'h0,         1, 0, 1, 0, 1, 32'h0000_02F8, 0, 0, 0);
    vecs[3]  = mk(2'b00, 3'b101, 32'h0000_0400, 32'h0000_0010, 32'h0,         1, 0, 1, 0, 0, 32'h0000_0410, 0, 0, 1);
    vecs[4]  = mk(2'b00, 3'b110, 32'h0000_0500, 32'h0000_0008, 32'h0,         0, 0, 1, 0, 0, 32'h0000_0508, 0, 0, 0);
    vecs[5]  = mk(2'b00, 3'b111, 32'h0000_0600, 32'h0000_0100, 32'h0,         0, 0, 1, 0, 1, 32'h0000_0700, 0, 0, 1);
    vecs[6]  = mk(2'b00, 3'b010, 32'h0000_0700, 32'h0000_0004, 32'h0,         0, 1, 1, 1, 0, 32'h0000_0704, 1, 0, 0);
    vecs[7]  = mk(2'b00, 3'b011, 32'h0000_0800, 32'h0000_000C, 32'h0,         0, 1, 1, 1, 0, 32'h0000_080C, 1, 0, 0);
    vecs[8]  = mk(2'b01, 3'b000, 32'h0000_0900, 32'h0000_0100, 32'h0,         1, 0, 0, 0, 1, 32'h0000_0A00, 0, 0, 0);
    vecs[9]  = mk(2'b01, 3'b000, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0,         0, 0, 0, 0, 1, 32'h0000_0010, 0, 0, 1);
    vecs[10] = mk(2'b10, 3'b000, 32'h0000_0B00, 32'h0000_0000, 32'h0000_1003, 1, 0, 0, 0, 1, 32'h0000_1002, 0, 1, 0);
    vecs[11] = mk(2'b10, 3'b000, 32'h0000_0B00, 32'h0000_0000, 32'h0000_1001, 1, 0, 0, 0, 1, 32'h0000_1000, 0, 0, 1);
    vecs[12] = mk(2'b11, 3'b000, 32'h0000_0C00, 32'h0000_0042, 32'h0,         1, 1, 0, 0, 0, 32'h0000_0C42, 0, 0, 0);
    vecs[13] = mk(2'b00, 3'b000, 32'h0000_0D00, 32'h0000_0006, 32'h0,         0, 1, 0, 0, 1, 32'h0000_0D06, 0, 1, 0);
    vecs[14] = mk(2'b10, 3'b000, 32'h0000_0E00, 32'h0000_0011, 32'h0000_2000, 0, 0, 0, 0, 1, 32'h0000_2010, 0, 0, 1);

    // Reset state
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checkBit("reset.out_valid", out_valid, 1'b0);
    checkBit("reset.redirect", redirect, 1'b0);
    checkBit("reset.in_ready", in_ready, 1'b1);
    checkOutput("reset.out_target", out_target, 32'h0);
    checkOutput("reset.redirect_pc", redirect_pc, 32'h0);
    checkCounters("reset");

    // Table of single instructions, each followed by enough idle cycles
    // for any drain window to close.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      if (vecs[i].bt == 2'b00) exp_branch++;
      if (vecs[i].exp_redirect) exp_mis++;
      checkVector(vecs[i], i);
      checkCounters($sformatf("v%0d", i));
      tick();
      checkBit($sformatf("v%0d.pulse", i), redirect, 1'b0);
      idle(3);
    end

    // Drain: mispredict followed by three back-to-back inputs; the first
    // two are discarded, the third comes out.
    drive(2'b00, 3'b000, 32'h0000_1000, 32'h0000_0040, 32'h0, 0, 1, 0, 0);
    tick();
    exp_branch++; exp_mis++;
    checkBit("drain.m.valid", out_valid, 1'b1);
    checkBit("drain.m.redirect", redirect, 1'b1);
    checkOutput("drain.m.redirect_pc", redirect_pc, 32'h0000_1040);
    drive(2'b00, 3'b000, 32'h0000_1100, 32'h0000_0040, 32'h0, 0, 1, 0, 0);
    tick();
    checkBit("drain.x1.valid", out_valid, 1'b0);
    checkBit("drain.x1.redirect", redirect, 1'b0);
    drive(2'b11, 3'b000, 32'h0000_1200, 32'h0, 32'h0, 0, 0, 0, 0);
    tick();
    checkBit("drain.x2.valid", out_valid, 1'b0);
    drive(2'b11, 3'b000, 32'h0000_1300, 32'h0, 32'h0, 0, 0, 0, 0);
    tick();
    checkBit("drain.x3.valid", out_valid, 1'b1);
    checkOutput("drain.x3.link", out_link, 32'h0000_1304);
    checkCounters("drain");
    idle(3);

    // Backpressure: redirect pulses once while the output stays frozen.
    out_ready = 1'b0;
    drive(2'b01, 3'b000, 32'h0000_2000, 32'h0000_0080, 32'h0, 0, 0, 0, 0);
    tick();
    exp_mis++;
    checkBit("stall.redirect", redirect, 1'b1);
    checkOutput("stall.target", out_target, 32'h0000_2080);
    drive(2'b11, 3'b000, 32'h0000_2100, 32'h0, 32'h0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkBit($sformatf("stall%0d.redirect", k), redirect, 1'b0);
      checkBit($sformatf("stall%0d.valid", k), out_valid, 1'b1);
      checkOutput($sformatf("stall%0d.target", k), out_target, 32'h0000_2080);
      checkOutput($sformatf("stall%0d.link", k), out_link, 32'h0000_2004);
      checkBit($sformatf("stall%0d.in_ready", k), in_ready, (k == 1));
    end
    checkCounters("stall");

    // Flush with a mispredicting input that would otherwise be accepted.
    out_ready = 1'b1;
    flush_in = 1'b1;
    drive(2'b00, 3'b000, 32'h0000_2200, 32'h0000_0010, 32'h0, 0, 1, 0, 0);
    tick();
    flush_in = 1'b0;
    in_valid = 1'b0;
    checkBit("flush.valid", out_valid, 1'b0);
    checkBit("flush.redirect", redirect, 1'b0);
    checkBit("flush.in_ready", in_ready, 1'b1);
    checkCounters("flush");
    tick();
    checkBit("flush.after.valid", out_valid, 1'b0);

    // Flush during a drain window returns to RUN immediately.
    drive(2'b00, 3'b000, 32'h0000_2300, 32'h0000_0010, 32'h0, 0, 1, 0, 0);
    tick();
    exp_branch++; exp_mis++;
    flush_in = 1'b1;
    drive(2'b11, 3'b000, 32'h0000_2400, 32'h0, 32'h0, 0, 0, 0, 0);
    tick();
    flush_in = 1'b0;
    checkBit("fdrain.flush.valid", out_valid, 1'b0);
    drive(2'b11, 3'b000, 32'h0000_2500, 32'h0, 32'h0, 0, 0, 0, 0);
    tick();
    checkBit("fdrain.next.valid", out_valid, 1'b1);
    checkOutput("fdrain.next.link", out_link, 32'h0000_2504);
    checkCounters("fdrain");
    idle(3);

    // Push the narrow counters past their all-ones ceiling.
    for (int j = 0; j < 3; j++) begin
      drive(2'b00, 3'b000, 32'h0000_3000 + 32'(j * 16), 32'h0000_0100, 32'h0, 0, 1, 0, 0);
      tick();
      exp_branch++; exp_mis++;
      checkCounters($sformatf("sat%0d", j));
      idle(3);
    end

    // Reset asserted in the middle of a drain window.
    drive(2'b00, 3'b000, 32'h0000_4000, 32'h0000_0020, 32'h0, 0, 1, 0, 0);
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_branch = 0; exp_mis = 0;
    checkBit("rstd.valid", out_valid, 1'b0);
    checkBit("rstd.redirect", redirect, 1'b0);
    checkBit("rstd.taken", out_taken, 1'b0);
    checkOutput("rstd.target", out_target, 32'h0);
    checkOutput("rstd.link", out_link, 32'h0);
    checkOutput("rstd.redirect_pc", redirect_pc, 32'h0);
    checkBit("rstd.in_ready", in_ready, 1'b1);
    checkCounters("rstd");
    rst_n = 1'b1;
    drive(2'b11, 3'b000, 32'h0000_5000, 32'h0, 32'h0, 0, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    checkBit("rstd.run.valid", out_valid, 1'b1);
    checkOutput("rstd.run.link", out_link, 32'h0000_5004);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage branch resolver for the RV32IM core. It takes the signed Greater/Equal/Less flags from the ALU comparator plus an unsigned-less flag, and decides whether a BEQ/BNE/BLT/BGE/BLTU/BGEU is taken. It also computes JAL/JALR/branch targets, checks the outcome against the fetch-stage prediction, and drives a one-cycle front-end redirect. After a redirect it drains wrong-path instructions; it keeps saturating branch and mispredict counters.

## Interface
- data_width, 32, operand/PC width
- CNT_W, 16, performance counter width
- DRAIN_CYCLES, 2, cycles of wrong-path discard after a redirect (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid / in_ready  in / out  1  upstream handshake
- br_type  in  2  00 cond branch, 01 JAL, 10 JALR, 11 non-branch
- funct3  in  3  branch condition
- pc, imm, rs1  in  data_width  instruction PC, sign-extended immediate, rs1 value
- pred_taken  in  1  fetch prediction
- cmp_greater, cmp_equal, cmp_less  in  1  signed flags from comparator
- cmp_ltu  in  1  unsigned rs1<rs2
- flush_in  in  1  kill from a later stage
- out_valid / out_ready  out / in  1  downstream handshake
- out_taken  out  1  resolved direction
- out_target  out  data_width  resolved target
- out_link  out  data_width  pc+4
- out_illegal, out_misalign  out  1  bad funct3 / target[1]=1
- redirect  out  1  one-cycle front-end redirect pulse
- redirect_pc  out  data_width  fetch restart address
- branch_cnt, mispredict_cnt  out  CNT_W  saturating counters

## Operation
- Taken decode:
  - 000 Equal; 001 !Equal; 100 Less; 101 !Less; 110 cmp_ltu; 111 !cmp_ltu.
  - 010/011: not taken, out_illegal=1.
  - JAL/JALR always taken; non-branch never taken, never redirects.
- Target: cond/JAL = pc+imm; JALR = (rs1+imm) & ~1. Addition modulo 2^data_width; wrap is silent.
- out_misalign = taken && target[1]. A misaligned instruction never redirects.
- Mispredict = (out_taken != pred_taken) for cond/JAL; JALR always mispredicts.
- redirect_pc = out_taken ? out_target : out_link.
- Pipeline register: in_ready = !out_valid || out_ready (RUN state). Accept on in_valid && in_ready.
- FSM:
  - RUN: on accepting a mispredicting instruction, go to DRAIN and load drain counter = DRAIN_CYCLES.
  - DRAIN: in_ready=1, accepted inputs discarded, counter decrements every cycle; at 1 → RUN.
- Counters:
  - branch_cnt +1 per accepted cond branch.
  - mispredict_cnt +1 per redirect.
  - Both saturate at all-ones; neither counts discarded or flushed instructions.
- flush_in: synchronous.
  - Clears out_valid, forces RUN, drops same-cycle input, suppresses a same-cycle redirect.
  - Precedence: flush_in > new mispredict > drain.

## Timing
- Latency 1: accepted at edge N → out_valid and result at N+1.
- redirect is registered, high for exactly the cycle after accept, even if out_ready=0. It never repeats while stalled.
- Under backpressure (out_valid && !out_ready), all out_* are held stable.
- Reset: out_valid, redirect, out_taken, out_illegal, out_misalign, all data outputs, counters = 0. State RUN. in_ready=1 after reset.
- Reset mid-DRAIN returns to RUN; pending redirect is lost.

## Structure
- Package rv32im_branch_pkg holds:
  - br_type_e enum.
  - F3_BEQ…F3_BGEU constants.
  - state enum {RUN, DRAIN}.
- Sub-module branch_cond_decode: combinational (funct3, flags) → taken, illegal.
- Top holds adders, pipeline register, FSM, drain counter and counters.

## Test plan
- BEQ, cmp_equal=1, pred_taken=0, pc=0x100, imm=0x20 → next cycle out_taken=1, target 0x120, redirect=1, redirect_pc=0x120, mispredict_cnt=1.
- BLTU, cmp_ltu=0, pred_taken=0 → out_taken=0, redirect=0, branch_cnt=1. Next two inputs are accepted normally.
- JALR, rs1=0x1003, imm=0 → target 0x1002, out_misalign=1, no redirect. With rs1=0x1001, target 0x1000 and redirect=1.
- Mispredict with DRAIN_CYCLES=2 and back-to-back in_valid → two following inputs discarded (no out_valid), third emitted.
- out_ready=0 for 3 cycles after mispredict → redirect high 1 cycle only, outputs stable, in_ready=0. flush_in with in_valid → out_valid=0, no count.
- funct3=010 → out_illegal=1, not taken. Counter at 0xFFFF + mispredict → stays 0xFFFF. rst_n low mid-DRAIN → all outputs 0, RUN.
